mesi_bus_arbiter: RTL and testbench

Snoopy-bus controller that shares the single coherence bus between the two MESI cache controllers (cache 1, cache 2).
- Accepts BusRd / BusRdX / BusUpgr requests, arbitrates round-robin and broadcasts the snoop to the non-master cache.
- Sequences the flush (dirty writeback) or memory fetch, then returns completion plus the shared indication (S vs E fill).
- Sits between the two cache FSMs and the memory port.

---
 rtl/mesi_bus_pkg.sv | 25 ++
 rtl/mesi_rr_arbiter.sv | 38 +++
 rtl/mesi_bus_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_mesi_bus_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mesi_bus_pkg.sv
// Shared definitions for the two-cache MESI snoopy-bus controller:
// bus command encodings, controller states and master identifiers.
package mesi_bus_pkg;

   localparam logic [1:0] BUS_RD   = 2'b00;
   localparam logic [1:0] BUS_RDX  = 2'b01;
   localparam logic [1:0] BUS_UPGR = 2'b10;
   localparam logic [1:0] BUS_RSVD = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SNOOP = 3'd1,
      ST_WB    = 3'd2,
      ST_MEM   = 3'd3,
      ST_DONE  = 3'd4
   } bus_state_t;

   localparam logic CACHE_1 = 1'b0;
   localparam logic CACHE_2 = 1'b1;

   function automatic logic other_cache(input logic id);
      return ~id;
   endfunction

endpackage

// File: rtl/mesi_rr_arbiter.sv
// Two-way round-robin picker. Holds the id of the last master served and
// favours the other cache when both request in the same cycle.
module mesi_rr_arbiter
   import mesi_bus_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic req_1,
   input  logic req_2,
   input  logic update,
   input  logic upd_id,
   output logic any_req,
   output logic pick_id
);

   logic last_gnt_reg;

   // Starting at CACHE_2 lets cache 1 win the first tie after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_gnt_reg <= CACHE_2;
      end else if (update) begin
         last_gnt_reg <= upd_id;
      end
   end

   always_comb begin
      any_req = req_1 | req_2;
      if (req_1 && req_2) begin
         pick_id = other_cache(last_gnt_reg);
      end else if (req_1) begin
         pick_id = CACHE_1;
      end else begin
         pick_id = CACHE_2;
      end
   end

endmodule

// File: rtl/mesi_bus_arbiter.sv
// Snoopy coherence-bus controller for two MESI caches: arbitration, snoop
// broadcast, flush/fetch sequencing. Define MESI_C2C_EN for cache-to-cache fills.
module mesi_bus_arbiter
   import mesi_bus_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int CMD_W  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_1,
   input  logic [CMD_W-1:0]  cmd_1,
   input  logic [ADDR_W-1:0] addr_1,
   output logic              gnt_1,
   output logic              done_1,
   output logic              shared_1,
   input  logic              req_2,
   input  logic [CMD_W-1:0]  cmd_2,
   input  logic [ADDR_W-1:0] addr_2,
   output logic              gnt_2,
   output logic              done_2,
   output logic              shared_2,
   output logic              snp_valid_1,
   output logic              snp_valid_2,
   output logic [CMD_W-1:0]  snp_cmd,
   output logic [ADDR_W-1:0] snp_addr,
   input  logic              snp_hit_1,
   input  logic              snp_hit_2,
   input  logic              snp_dirty_1,
   input  logic              snp_dirty_2,
   output logic              mem_rd_req,
   output logic              mem_wr_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   output logic              flush_opt,
   output logic              busy
);

   bus_state_t        state_reg, state_next;
   logic              master_reg, master_next;
   logic [CMD_W-1:0]  cmd_reg, cmd_next;
   logic [ADDR_W-1:0] addr_reg, addr_next;
   logic              hit_reg, hit_next;

   logic              any_req, pick_id;
   logic [CMD_W-1:0]  sel_cmd;
   logic [ADDR_W-1:0] sel_addr;
   logic              snp_hit_sel, snp_dirty_sel;

   logic              gnt_1_d, gnt_2_d, done_1_d, done_2_d, shared_d;
   logic              snp_valid_1_d, snp_valid_2_d;
   logic [CMD_W-1:0]  snp_cmd_d;
   logic [ADDR_W-1:0] snp_addr_d, mem_addr_d;
   logic              mem_rd_req_d, mem_wr_req_d, flush_opt_d, busy_d;

   mesi_rr_arbiter u_rr (
      .clk     (clk),
      .rst_n   (rst_n),
      .req_1   (req_1),
      .req_2   (req_2),
      .update  (state_reg == ST_DONE),
      .upd_id  (master_reg),
      .any_req (any_req),
      .pick_id (pick_id)
   );

   assign sel_cmd  = (pick_id == CACHE_1) ? cmd_1 : cmd_2;
   assign sel_addr = (pick_id == CACHE_1) ? addr_1 : addr_2;

   // The snooper is always the cache that does not own the bus.
   assign snp_hit_sel   = (master_reg == CACHE_1) ? snp_hit_2   : snp_hit_1;
   assign snp_dirty_sel = (master_reg == CACHE_1) ? snp_dirty_2 : snp_dirty_1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= ST_IDLE;
         master_reg <= CACHE_1;
         cmd_reg    <= '0;
         addr_reg   <= '0;
         hit_reg    <= 1'b0;
      end else begin
         state_reg  <= state_next;
         master_reg <= master_next;
         cmd_reg    <= cmd_next;
         addr_reg   <= addr_next;
         hit_reg    <= hit_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      master_next = master_reg;
      cmd_next    = cmd_reg;
      addr_next   = addr_reg;
      hit_next    = hit_reg;
      case (state_reg)
         ST_IDLE: begin
            if (any_req) begin
               master_next = pick_id;
               cmd_next    = sel_cmd;
               addr_next   = sel_addr;
               hit_next    = 1'b0;
               state_next  = (sel_cmd == BUS_RSVD) ? ST_DONE : ST_SNOOP;
            end
         end
         ST_SNOOP: begin
            // A flushing owner necessarily still holds a copy.
            hit_next = snp_hit_sel | snp_dirty_sel;
            if (cmd_reg == BUS_UPGR) begin
               state_next = ST_DONE;
            end else if (snp_dirty_sel && (cmd_reg == BUS_RD || cmd_reg == BUS_RDX)) begin
               state_next = ST_WB;
            end else if (snp_hit_sel && cmd_reg == BUS_RD) begin
`ifdef MESI_C2C_EN
               state_next = ST_DONE;
`else
               state_next = ST_MEM;
`endif
            end else begin
               state_next = ST_MEM;
            end
         end
         ST_WB, ST_MEM: begin
            if (mem_ack) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // Outputs are derived from the next state so the registered copies line
   // up with the state they describe.
   always_comb begin
      busy_d        = (state_next != ST_IDLE);
      gnt_1_d       = busy_d && (master_next == CACHE_1);
      gnt_2_d       = busy_d && (master_next == CACHE_2);
      done_1_d      = (state_next == ST_DONE) && (master_next == CACHE_1);
      done_2_d      = (state_next == ST_DONE) && (master_next == CACHE_2);
      shared_d      = (cmd_next == BUS_RD) && hit_next;
      snp_valid_1_d = (state_next == ST_SNOOP) && (master_next == CACHE_2);
      snp_valid_2_d = (state_next == ST_SNOOP) && (master_next == CACHE_1);
      snp_cmd_d     = (state_next == ST_SNOOP) ? cmd_next : '0;
      snp_addr_d    = (state_next == ST_SNOOP) ? addr_next : '0;
      mem_rd_req_d  = (state_next == ST_MEM);
      mem_wr_req_d  = (state_next == ST_WB);
      mem_addr_d    = (mem_rd_req_d || mem_wr_req_d) ? addr_next : '0;
`ifdef MESI_C2C_EN
      flush_opt_d   = (state_reg == ST_SNOOP) && (state_next == ST_DONE) &&
                      (cmd_reg == BUS_RD);
`else
      flush_opt_d   = 1'b0;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt_1       <= 1'b0;
         gnt_2       <= 1'b0;
         done_1      <= 1'b0;
         done_2      <= 1'b0;
         shared_1    <= 1'b0;
         shared_2    <= 1'b0;
         snp_valid_1 <= 1'b0;
         snp_valid_2 <= 1'b0;
         snp_cmd     <= '0;
         snp_addr    <= '0;
         mem_rd_req  <= 1'b0;
         mem_wr_req  <= 1'b0;
         mem_addr    <= '0;
         flush_opt   <= 1'b0;
         busy        <= 1'b0;
      end else begin
         gnt_1       <= gnt_1_d;
         gnt_2       <= gnt_2_d;
         done_1      <= done_1_d;
         done_2      <= done_2_d;
         shared_1    <= done_1_d && shared_d;
         shared_2    <= done_2_d && shared_d;
         snp_valid_1 <= snp_valid_1_d;
         snp_valid_2 <= snp_valid_2_d;
         snp_cmd     <= snp_cmd_d;
         snp_addr    <= snp_addr_d;
         mem_rd_req  <= mem_rd_req_d;
         mem_wr_req  <= mem_wr_req_d;
         mem_addr    <= mem_addr_d;
         flush_opt   <= flush_opt_d;
         busy        <= busy_d;
      end
   end

endmodule

// File: tb/tb_mesi_bus_arbiter.sv
// Directed bench for mesi_bus_arbiter: fills, upgrade, writeback, reserved
// command, round-robin order, clean-hit path and asynchronous reset.
`timescale 1ns/1ps
module tb_mesi_bus_arbiter;

   localparam int ADDR_W = 32;
   localparam int CMD_W  = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              req_1, req_2;
   logic [CMD_W-1:0]  cmd_1, cmd_2;
   logic [ADDR_W-1:0] addr_1, addr_2;
   logic              gnt_1, gnt_2, done_1, done_2, shared_1, shared_2;
   logic              snp_valid_1, snp_valid_2;
   logic [CMD_W-1:0]  snp_cmd;
   logic [ADDR_W-1:0] snp_addr;
   logic              snp_hit_1, snp_hit_2, snp_dirty_1, snp_dirty_2;
   logic              mem_rd_req, mem_wr_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ack;
   logic              flush_opt, busy;

   int total = 0;
   int bad = 0;
   int mem_cnt = 0;
   int overlap_cnt = 0;

   mesi_bus_arbiter #(.ADDR_W(ADDR_W), .CMD_W(CMD_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_1(req_1), .cmd_1(cmd_1), .addr_1(addr_1),
      .gnt_1(gnt_1), .done_1(done_1), .shared_1(shared_1),
      .req_2(req_2), .cmd_2(cmd_2), .addr_2(addr_2),
      .gnt_2(gnt_2), .done_2(done_2), .shared_2(shared_2),
      .snp_valid_1(snp_valid_1), .snp_valid_2(snp_valid_2),
      .snp_cmd(snp_cmd), .snp_addr(snp_addr),
      .snp_hit_1(snp_hit_1), .snp_hit_2(snp_hit_2),
      .snp_dirty_1(snp_dirty_1), .snp_dirty_2(snp_dirty_2),
      .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
      .mem_ack(mem_ack), .flush_opt(flush_opt), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (mem_rd_req || mem_wr_req) mem_cnt <= mem_cnt + 1;
   always @(negedge clk) if (gnt_1 && gnt_2) overlap_cnt <= overlap_cnt + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Waits (bounded) for a memory request, checks its address, then returns
   // an ack 'delay' cycles after the request was first seen. Returns at the
   // negedge following the ack cycle.
   task automatic mem_respond(input int delay, input logic [31:0] exp_addr, input string tag);
      int n = 0;
      while (!(mem_rd_req || mem_wr_req) && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_mem_req_seen"}, 32'(mem_rd_req | mem_wr_req), 1);
      check({tag, "_mem_addr"}, mem_addr, exp_addr);
      repeat (delay - 1) @(negedge clk);
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int mc;
      int k;
      int order [3];

      rst_n = 1'b0;
      req_1 = 1'b0; cmd_1 = '0; addr_1 = '0;
      req_2 = 1'b0; cmd_2 = '0; addr_2 = '0;
      snp_hit_1 = 1'b0; snp_hit_2 = 1'b0; snp_dirty_1 = 1'b0; snp_dirty_2 = 1'b0;
      mem_ack = 1'b0;
      order = '{0, 0, 0};

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_flags", {20'd0, gnt_1, gnt_2, done_1, done_2, shared_1, shared_2,
                          snp_valid_1, snp_valid_2, mem_rd_req, mem_wr_req, flush_opt, busy}, 0);
      check("rst_addrs", snp_addr | mem_addr, 0);
      rst_n = 1'b1;

      // Cache 1 BusRd addr 5, no hits -> memory fetch
      req_1 = 1'b1; cmd_1 = 2'b00; addr_1 = 32'd5;
      @(negedge clk);
      check("rd_gnt_1", gnt_1, 1);
      check("rd_gnt_2", gnt_2, 0);
      check("rd_snp_valid_2", snp_valid_2, 1);
      check("rd_snp_valid_1", snp_valid_1, 0);
      check("rd_snp_addr", snp_addr, 5);
      check("rd_snp_cmd", snp_cmd, 0);
      @(negedge clk);
      check("rd_mem_rd", mem_rd_req, 1);
      check("rd_mem_wr", mem_wr_req, 0);
      mem_respond(3, 32'd5, "rd");
      check("rd_done_1", done_1, 1);
      check("rd_shared_1", shared_1, 0);
      check("rd_mem_rd_drop", mem_rd_req, 0);
      check("rd_gnt_in_done", gnt_1, 1);
      req_1 = 1'b0;
      @(negedge clk);
      check("rd_idle_busy", busy, 0);
      check("rd_idle_done", done_1, 0);

      // Cache 1 BusUpgr with a snoop hit -> done 2 cycles after the request edge
      mc = mem_cnt;
      snp_hit_2 = 1'b1;
      req_1 = 1'b1; cmd_1 = 2'b10; addr_1 = 32'd5;
      @(negedge clk);
      check("upg_snp_cmd", snp_cmd, 2);
      check("upg_done_early", done_1, 0);
      @(negedge clk);
      check("upg_done_1", done_1, 1);
      check("upg_shared_1", shared_1, 0);
      req_1 = 1'b0; snp_hit_2 = 1'b0;
      @(negedge clk);
      check("upg_no_mem", mem_cnt - mc, 0);
      check("upg_idle", busy, 0);

      // Cache 2 BusRd addr 5, cache 1 dirty -> writeback then shared fill
      snp_hit_1 = 1'b1; snp_dirty_1 = 1'b1;
      req_2 = 1'b1; cmd_2 = 2'b00; addr_2 = 32'd5;
      @(negedge clk);
      check("wb_gnt_2", gnt_2, 1);
      check("wb_snp_valid_1", snp_valid_1, 1);
      @(negedge clk);
      check("wb_mem_wr", mem_wr_req, 1);
      check("wb_mem_rd", mem_rd_req, 0);
      cmd_2 = 2'b01; addr_2 = 32'h77;
      mem_respond(2, 32'd5, "wb");
      check("wb_done_2", done_2, 1);
      check("wb_shared_2", shared_2, 1);
      check("wb_mem_wr_drop", mem_wr_req, 0);
      req_2 = 1'b0; snp_hit_1 = 1'b0; snp_dirty_1 = 1'b0;
      @(negedge clk);

      // Reserved command -> straight to DONE, no snoop or memory
      mc = mem_cnt;
      req_2 = 1'b1; cmd_2 = 2'b11; addr_2 = 32'd8;
      @(negedge clk);
      check("rsv_done_2", done_2, 1);
      check("rsv_shared_2", shared_2, 0);
      check("rsv_no_snoop", snp_valid_1, 0);
      req_2 = 1'b0;
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      @(negedge clk);
      check("rsv_stray_ack_idle", busy, 0);
      check("rsv_no_mem", mem_cnt - mc, 0);

      // Clean snoop hit on BusRd
      snp_hit_2 = 1'b1;
      req_1 = 1'b1; cmd_1 = 2'b00; addr_1 = 32'd9;
      @(negedge clk);
      @(negedge clk);
`ifdef MESI_C2C_EN
      check("c2c_done_1", done_1, 1);
      check("c2c_flush_opt", flush_opt, 1);
      check("c2c_no_mem_rd", mem_rd_req, 0);
      check("c2c_shared_1", shared_1, 1);
`else
      check("c2c_mem_rd", mem_rd_req, 1);
      check("c2c_flush_opt_off", flush_opt, 0);
      mem_respond(1, 32'd9, "c2c");
      check("c2c_done_1", done_1, 1);
      check("c2c_shared_1", shared_1, 1);
      check("c2c_flush_opt_done", flush_opt, 0);
`endif
      req_1 = 1'b0; snp_hit_2 = 1'b0;
      @(negedge clk);

      // Round-robin from reset with both caches holding their requests
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      req_1 = 1'b1; cmd_1 = 2'b10; addr_1 = 32'd1;
      req_2 = 1'b1; cmd_2 = 2'b10; addr_2 = 32'd2;
      k = 0;
      for (int i = 0; i < 40 && k < 3; i++) begin
         @(negedge clk);
         if (done_1 || done_2) begin
            order[k] = done_2 ? 2 : 1;
            $display("rr transaction %0d granted cache %0d", k, order[k]);
            k++;
         end
      end
      req_1 = 1'b0; req_2 = 1'b0;
      check("rr_count", k, 3);
      check("rr_first", order[0], 1);
      check("rr_second", order[1], 2);
      check("rr_third", order[2], 1);
      check("rr_no_overlap", overlap_cnt, 0);
      @(negedge clk);

      // Asynchronous reset in the middle of a fetch
      req_2 = 1'b1; cmd_2 = 2'b01; addr_2 = 32'd7;
      @(negedge clk);
      @(negedge clk);
      check("arst_mem_rd_before", mem_rd_req, 1);
      req_2 = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("arst_mem_rd", mem_rd_req, 0);
      check("arst_gnt_2", gnt_2, 0);
      check("arst_busy", busy, 0);
      @(negedge clk);
      check("arst_no_done", done_2, 0);
      rst_n = 1'b1;
      req_1 = 1'b1; cmd_1 = 2'b10; addr_1 = 32'd3;
      @(negedge clk);
      check("post_rst_gnt_1", gnt_1, 1);
      check("post_rst_snp_addr", snp_addr, 3);
      @(negedge clk);
      check("post_rst_done_1", done_1, 1);
      req_1 = 1'b0;
      @(negedge clk);
      check("post_rst_idle", busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
